// File: rtl/pipelined_cpu_fwd_if.sv
// rtl/pipelined_cpu_fwd_if.sv - program-load, debug and retire signals of the pipelined core
interface pipelined_cpu_fwd_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 8
);
    logic              imem_we;
    logic [PC_W-1:0]   imem_waddr;
    logic [31:0]       imem_wdata;
    logic [4:0]        dbg_raddr;
    logic [DATA_W-1:0] dbg_rdata;
    logic              retire_valid;
    logic [PC_W-1:0]   retire_pc;
    logic              retire_we;
    logic [4:0]        retire_rd;
    logic [DATA_W-1:0] retire_data;
    logic [15:0]       stall_count;
    logic              halted;

    modport master (
        output imem_we, imem_waddr, imem_wdata, dbg_raddr,
        input  dbg_rdata, retire_valid, retire_pc, retire_we, retire_rd, retire_data,
               stall_count, halted
    );

    modport slave (
        input  imem_we, imem_waddr, imem_wdata, dbg_raddr,
        output dbg_rdata, retire_valid, retire_pc, retire_we, retire_rd, retire_data,
               stall_count, halted
    );
endinterface

// File: rtl/pipelined_cpu_fwd.sv
// rtl/pipelined_cpu_fwd.sv - five-stage pipelined core with switchable EX forwarding
module pipelined_cpu_fwd #(
    parameter int DATA_W     = 32,
    parameter int IMEM_DEPTH = 256,
    parameter int DMEM_DEPTH = 256,
    parameter int FORWARD_EN = 1
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_cpu_fwd_if.slave bus
);
    localparam int PC_W    = $clog2(IMEM_DEPTH);
    localparam int DMEM_AW = $clog2(DMEM_DEPTH);

    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_BEQ  = 6'h10;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    logic [31:0]       r_imem [0:IMEM_DEPTH-1];
    logic [DATA_W-1:0] r_dmem [0:DMEM_DEPTH-1];
    logic [DATA_W-1:0] r_regs [0:31];

    logic [PC_W-1:0]   r_pc;
    logic              r_fetch_stop;
    logic              r_ifid_valid;
    logic [PC_W-1:0]   r_ifid_pc;
    logic [31:0]       r_ifid_instr;
    logic              r_idex_valid, r_idex_we;
    logic [PC_W-1:0]   r_idex_pc;
    logic [5:0]        r_idex_op;
    logic [4:0]        r_idex_rs, r_idex_rt, r_idex_dst;
    logic [DATA_W-1:0] r_idex_a, r_idex_b, r_idex_imm;
    logic              r_exmem_valid, r_exmem_we;
    logic [PC_W-1:0]   r_exmem_pc;
    logic [5:0]        r_exmem_op;
    logic [4:0]        r_exmem_dst;
    logic [DATA_W-1:0] r_exmem_res, r_exmem_sdata;
    logic              r_memwb_valid, r_memwb_we;
    logic [PC_W-1:0]   r_memwb_pc;
    logic [4:0]        r_memwb_dst;
    logic [DATA_W-1:0] r_memwb_data;
    logic [15:0]       r_stall_cnt;
    logic              r_halted;

    logic [5:0]        w_id_op;
    logic [4:0]        w_id_rs, w_id_rt, w_id_dst;
    logic [DATA_W-1:0] w_id_imm, w_id_a, w_id_b;
    logic              w_id_rtype, w_id_we, w_use_rs, w_use_rt, w_stall_raw, w_stall_id, w_halt_id;
    logic [DATA_W-1:0] w_ex_a, w_ex_b, w_alu;
    logic              w_taken;
    logic [PC_W-1:0]   w_target;
    logic [DATA_W-1:0] w_load, w_wb_data;

    // ID decode, source detection and register read with same-cycle WB bypass
    always_comb begin
        w_id_op    = r_ifid_instr[31:26];
        w_id_rs    = r_ifid_instr[25:21];
        w_id_rt    = r_ifid_instr[20:16];
        w_id_imm   = {{(DATA_W-16){r_ifid_instr[15]}}, r_ifid_instr[15:0]};
        w_id_rtype = (w_id_op == OP_ADD) || (w_id_op == OP_SUB) || (w_id_op == OP_AND) || (w_id_op == OP_OR);
        w_id_dst   = 5'd0;
        if (w_id_rtype)                                 w_id_dst = r_ifid_instr[15:11];
        else if (w_id_op == OP_ADDI || w_id_op == OP_LW) w_id_dst = w_id_rt;
        w_id_we    = (w_id_dst != 5'd0);
        w_use_rs   = r_ifid_valid && (w_id_rs != 5'd0) && (w_id_rtype || w_id_op == OP_ADDI ||
                     w_id_op == OP_LW || w_id_op == OP_SW || w_id_op == OP_BEQ);
        w_use_rt   = r_ifid_valid && (w_id_rt != 5'd0) && (w_id_rtype || w_id_op == OP_SW || w_id_op == OP_BEQ);
        w_id_a     = r_regs[w_id_rs];
        if (w_id_rs == 5'd0) w_id_a = '0;
        else if (r_memwb_valid && r_memwb_we && r_memwb_dst == w_id_rs) w_id_a = r_memwb_data;
        w_id_b     = r_regs[w_id_rt];
        if (w_id_rt == 5'd0) w_id_b = '0;
        else if (r_memwb_valid && r_memwb_we && r_memwb_dst == w_id_rt) w_id_b = r_memwb_data;
    end

    // hazard detection: load-use only with forwarding, any EX/MEM producer without it
    always_comb begin
        w_stall_raw = 1'b0;
        if (FORWARD_EN != 0) begin
            w_stall_raw = r_idex_valid && r_idex_we && (r_idex_op == OP_LW) &&
                          ((w_use_rs && w_id_rs == r_idex_dst) || (w_use_rt && w_id_rt == r_idex_dst));
        end else begin
            w_stall_raw = (r_idex_valid && r_idex_we &&
                           ((w_use_rs && w_id_rs == r_idex_dst) || (w_use_rt && w_id_rt == r_idex_dst))) ||
                          (r_exmem_valid && r_exmem_we &&
                           ((w_use_rs && w_id_rs == r_exmem_dst) || (w_use_rt && w_id_rt == r_exmem_dst)));
        end
        w_stall_id = w_stall_raw && !w_taken;
        w_halt_id  = r_ifid_valid && (w_id_op == OP_HALT) && !w_taken;
    end

    // EX operand forwarding (EX/MEM beats MEM/WB), ALU and branch resolution
    always_comb begin
        w_ex_a = r_idex_a;
        w_ex_b = r_idex_b;
        if (FORWARD_EN != 0) begin
            if (r_exmem_valid && r_exmem_we && r_exmem_dst == r_idex_rs)      w_ex_a = r_exmem_res;
            else if (r_memwb_valid && r_memwb_we && r_memwb_dst == r_idex_rs) w_ex_a = r_memwb_data;
            if (r_exmem_valid && r_exmem_we && r_exmem_dst == r_idex_rt)      w_ex_b = r_exmem_res;
            else if (r_memwb_valid && r_memwb_we && r_memwb_dst == r_idex_rt) w_ex_b = r_memwb_data;
        end
        w_alu = '0;
        case (r_idex_op)
            OP_ADD:                 w_alu = w_ex_a + w_ex_b;
            OP_SUB:                 w_alu = w_ex_a - w_ex_b;
            OP_AND:                 w_alu = w_ex_a & w_ex_b;
            OP_OR:                  w_alu = w_ex_a | w_ex_b;
            OP_ADDI, OP_LW, OP_SW:  w_alu = w_ex_a + r_idex_imm;
            default:                w_alu = '0;
        endcase
        w_taken  = r_idex_valid && (r_idex_op == OP_BEQ) && (w_ex_a == w_ex_b);
        w_target = r_idex_pc + PC_W'(1) + r_idex_imm[PC_W-1:0];
    end

    // MEM-stage combinational load and writeback value select
    always_comb begin
        w_load    = r_dmem[r_exmem_res[DMEM_AW-1:0]];
        w_wb_data = (r_exmem_op == OP_LW) ? w_load : r_exmem_res;
    end

    // pipeline registers: flush beats stall beats halt beats normal fetch
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc <= '0;  r_fetch_stop <= 1'b0;
            r_ifid_valid <= 1'b0;  r_ifid_pc <= '0;  r_ifid_instr <= '0;
            r_idex_valid <= 1'b0;  r_idex_we <= 1'b0;  r_idex_pc <= '0;  r_idex_op <= '0;
            r_idex_rs <= '0;  r_idex_rt <= '0;  r_idex_dst <= '0;
            r_idex_a <= '0;  r_idex_b <= '0;  r_idex_imm <= '0;
            r_exmem_valid <= 1'b0;  r_exmem_we <= 1'b0;  r_exmem_pc <= '0;  r_exmem_op <= '0;
            r_exmem_dst <= '0;  r_exmem_res <= '0;  r_exmem_sdata <= '0;
            r_memwb_valid <= 1'b0;  r_memwb_we <= 1'b0;  r_memwb_pc <= '0;
            r_memwb_dst <= '0;  r_memwb_data <= '0;
            r_stall_cnt <= '0;  r_halted <= 1'b0;
        end else begin
            if (w_taken) begin
                r_pc         <= w_target;
                r_ifid_valid <= 1'b0;
            end else if (w_stall_raw) begin
                r_pc         <= r_pc;
            end else if (w_halt_id || r_fetch_stop) begin
                r_ifid_valid <= 1'b0;
            end else begin
                r_pc         <= r_pc + PC_W'(1);
                r_ifid_valid <= 1'b1;
                r_ifid_pc    <= r_pc;
                r_ifid_instr <= r_imem[r_pc];
            end
            if (w_halt_id) r_fetch_stop <= 1'b1;

            r_idex_valid <= r_ifid_valid && !w_taken && !w_stall_raw;
            r_idex_we    <= w_id_we;
            r_idex_pc    <= r_ifid_pc;
            r_idex_op    <= w_id_op;
            r_idex_rs    <= w_id_rs;
            r_idex_rt    <= w_id_rt;
            r_idex_dst   <= w_id_dst;
            r_idex_a     <= w_id_a;
            r_idex_b     <= w_id_b;
            r_idex_imm   <= w_id_imm;

            r_exmem_valid <= r_idex_valid;
            r_exmem_we    <= r_idex_we;
            r_exmem_pc    <= r_idex_pc;
            r_exmem_op    <= r_idex_op;
            r_exmem_dst   <= r_idex_dst;
            r_exmem_res   <= w_alu;
            r_exmem_sdata <= w_ex_b;

            r_memwb_valid <= r_exmem_valid;
            if (r_exmem_valid) begin
                r_memwb_we   <= r_exmem_we;
                r_memwb_pc   <= r_exmem_pc;
                r_memwb_dst  <= r_exmem_dst;
                r_memwb_data <= w_wb_data;
                if (r_exmem_op == OP_HALT) r_halted <= 1'b1;
            end

            if (w_stall_id && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // register file: cleared by reset, written from WB
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (r_memwb_valid && r_memwb_we) begin
            r_regs[r_memwb_dst] <= r_memwb_data;
        end
    end

    // data memory store from MEM; suppressed on the reset edge
    always_ff @(posedge clk) begin
        if (reset && r_exmem_valid && r_exmem_op == OP_SW) r_dmem[r_exmem_res[DMEM_AW-1:0]] <= r_exmem_sdata;
    end

    // instruction memory load port
    always_ff @(posedge clk) begin
        if (bus.imem_we) r_imem[bus.imem_waddr] <= bus.imem_wdata;
    end

    assign bus.dbg_rdata    = (bus.dbg_raddr == 5'd0) ? '0 : r_regs[bus.dbg_raddr];
    assign bus.retire_valid = r_memwb_valid;
    assign bus.retire_pc    = r_memwb_pc;
    assign bus.retire_we    = r_memwb_we;
    assign bus.retire_rd    = r_memwb_dst;
    assign bus.retire_data  = r_memwb_data;
    assign bus.stall_count  = r_stall_cnt;
    assign bus.halted       = r_halted;
endmodule
